// File: rtl/perf_event_counters.sv
// Per-event performance counter bank with free-running cycle counter.
// Freezes on HALT; counters read back through a registered port.
module perf_event_counters #(
  parameter int                    NUM_EVENTS = 8,
  parameter int                    CNT_WIDTH  = 32,
  parameter logic [NUM_EVENTS-1:0] EDGE_MASK  = '0,
  parameter bit                    SATURATE   = 1'b1,
  parameter int                    SEL_W      = $clog2(NUM_EVENTS+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clear,
  input  logic                  halt,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic                  rd_en,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic                  rd_valid,
  output logic [NUM_EVENTS:0]   overflow,
  output logic                  running,
  output logic                  frozen
);

  localparam int NC = NUM_EVENTS + 1;
  localparam logic [SEL_W-1:0] CYC_SEL = SEL_W'(NUM_EVENTS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FROZEN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CNT_WIDTH-1:0]  cnt_q [NC];
  logic [NUM_EVENTS-1:0] event_d;
  logic [NC-1:0]         ovf_q;
  logic [NC-1:0]         inc;
  logic                  count_en;
  logic [SEL_W-1:0]      sel_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (en) state_d = RUN;
        RUN: begin
          if (halt)     state_d = FROZEN;
          else if (!en) state_d = IDLE;
        end
        FROZEN:  state_d = FROZEN;
        default: state_d = IDLE;
      endcase
    end
  end

  assign count_en = (state_q == RUN) && !clear;

  // Edge channels only count when the previous sample was low.
  assign inc = {1'b1, event_in & ~(event_d & EDGE_MASK)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_d <= '0;
    end else begin
      event_d <= event_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q <= '0;
    end else if (clear) begin
      for (int i = 0; i < NC; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q <= '0;
    end else if (count_en) begin
      for (int i = 0; i < NC; i++) begin
        if (inc[i]) begin
          if (&cnt_q[i]) begin
            ovf_q[i] <= 1'b1;
            if (!SATURATE) cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  assign sel_idx = (rd_sel >= CYC_SEL) ? CYC_SEL : rd_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= cnt_q[sel_idx];
    end
  end

  assign overflow = ovf_q;
  assign running  = (state_q == RUN);
  assign frozen   = (state_q == FROZEN);

endmodule

// File: tb/tb_perf_event_counters.sv
// Bench for perf_event_counters: saturating and wrapping banks
// driven in parallel against a queue-based reference model.
module tb_perf_event_counters;

  localparam int NE = 4;
  localparam int W  = 4;
  localparam int SW = 3;
  localparam int NC = NE + 1;
  localparam int MAXV = 15;
  localparam logic [NE-1:0] EM = 4'b0010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic clear = 1'b0;
  logic halt = 1'b0;
  logic rd_en = 1'b0;
  logic [NE-1:0] ev = '0;
  logic [SW-1:0] sel = '0;

  logic [W-1:0]  rd_s, rd_w;
  logic          v_s, v_w;
  logic [NC-1:0] of_s, of_w;
  logic          run_s, run_w, fr_s, fr_w;

  perf_event_counters #(
    .NUM_EVENTS(NE), .CNT_WIDTH(W), .EDGE_MASK(EM), .SATURATE(1'b1)
  ) u_sat (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .halt(halt),
    .event_in(ev), .rd_en(rd_en), .rd_sel(sel),
    .rd_data(rd_s), .rd_valid(v_s), .overflow(of_s),
    .running(run_s), .frozen(fr_s)
  );

  perf_event_counters #(
    .NUM_EVENTS(NE), .CNT_WIDTH(W), .EDGE_MASK(EM), .SATURATE(1'b0)
  ) u_wrap (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .halt(halt),
    .event_in(ev), .rd_en(rd_en), .rd_sel(sel),
    .rd_data(rd_w), .rd_valid(v_w), .overflow(of_w),
    .running(run_w), .frozen(fr_w)
  );

  always #5 clk = ~clk;

  int    ms[NC];
  int    mw[NC];
  bit    ofs[NC];
  bit    ofw[NC];
  bit    prev[NE];
  string mst = "IDLE";
  int    qs[$];
  int    qw[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [NC-1:0] pk(input bit a[NC]);
    logic [NC-1:0] r;
    for (int i = 0; i < NC; i++) r[i] = a[i];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    int  k;
    bit  hit;
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        ms[i] = 0; mw[i] = 0; ofs[i] = 0; ofw[i] = 0;
      end
      for (int i = 0; i < NE; i++) prev[i] = 0;
      mst = "IDLE";
      qs.delete();
      qw.delete();
    end else begin
      if (rd_en) begin
        k = (int'(sel) >= NE) ? NE : int'(sel);
        qs.push_back(ms[k]);
        qw.push_back(mw[k]);
      end
      if (clear) begin
        for (int i = 0; i < NC; i++) begin
          ms[i] = 0; mw[i] = 0; ofs[i] = 0; ofw[i] = 0;
        end
        mst = "IDLE";
      end else begin
        if (mst == "RUN") begin
          for (int i = 0; i < NC; i++) begin
            if (i == NE)    hit = 1;
            else if (EM[i]) hit = ev[i] && !prev[i];
            else            hit = ev[i];
            if (hit) begin
              if (ms[i] == MAXV) ofs[i] = 1;
              else               ms[i] = ms[i] + 1;
              if (mw[i] == MAXV) ofw[i] = 1;
              mw[i] = (mw[i] + 1) % (MAXV + 1);
            end
          end
        end
        if (mst == "IDLE") begin
          if (en) mst = "RUN";
        end else if (mst == "RUN") begin
          if (halt)     mst = "FROZEN";
          else if (!en) mst = "IDLE";
        end
      end
      for (int i = 0; i < NE; i++) prev[i] = ev[i];
    end
  end

  always @(negedge clk) begin
    int e;
    chk("running_s", 32'(run_s), 32'(mst == "RUN"));
    chk("running_w", 32'(run_w), 32'(mst == "RUN"));
    chk("frozen_s", 32'(fr_s), 32'(mst == "FROZEN"));
    chk("frozen_w", 32'(fr_w), 32'(mst == "FROZEN"));
    chk("overflow_s", 32'(of_s), 32'(pk(ofs)));
    chk("overflow_w", 32'(of_w), 32'(pk(ofw)));
    chk("rd_valid_s", 32'(v_s), 32'(qs.size() != 0));
    chk("rd_valid_w", 32'(v_w), 32'(qw.size() != 0));
    if (qs.size() != 0) begin
      e = qs.pop_front();
      if (v_s) chk("rd_data_s", 32'(rd_s), 32'(e));
    end
    if (qw.size() != 0) begin
      e = qw.pop_front();
      if (v_w) chk("rd_data_w", 32'(rd_w), 32'(e));
    end
  end

  task automatic step(input logic e, input logic c, input logic h,
                      input logic [NE-1:0] v, input logic r,
                      input logic [SW-1:0] s);
    #1;
    en = e; clear = c; halt = h; ev = v; rd_en = r; sel = s;
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] pat;
    pat = 6'b101011;
    repeat (2) @(negedge clk);
    chk("reset_rd_data", 32'(rd_s), 32'd0);
    chk("reset_overflow", 32'(of_s), 32'd0);
    #1 rst = 1'b0;

    // level counting then halt
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0);
    repeat (5) step(1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd0);
    chk("halt_frozen", 32'(fr_s), 32'd1);
    repeat (3) step(1'b1, 1'b0, 1'b1, 4'b1111, 1'b0, 3'd0);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd0);
    chk("ch0_level_s", 32'(rd_s), 32'd5);
    chk("ch0_level_w", 32'(rd_w), 32'd5);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd4);
    chk("cycle_with_halt", 32'(rd_s), 32'd6);

    // edge mode, event held high across IDLE->RUN
    step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd0);
    step(1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 3'd0);
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 1'b0, {2'b00, pat[i], 1'b0}, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd1);
    chk("ch1_edge_held", 32'(rd_s), 32'd2);

    // edge mode from low
    step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0);
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 1'b0, {2'b00, pat[i], 1'b0}, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd1);
    chk("ch1_edge", 32'(rd_s), 32'd3);

    // overflow: 17 level events into a 4-bit counter
    step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0);
    repeat (17) step(1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd2);
    chk("ch2_saturate", 32'(rd_s), 32'd15);
    chk("ch2_wrap", 32'(rd_w), 32'd1);
    chk("ch2_ovf_s", 32'(of_s[2]), 32'd1);
    chk("ch2_ovf_w", 32'(of_w[2]), 32'd1);

    // read in the same cycle as an increment
    step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0);
    repeat (7) step(1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 3'd2);
    chk("read_pre_inc", 32'(rd_s), 32'd7);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd2);
    chk("reread", 32'(rd_s), 32'd8);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd4);
    chk("sel_ne_cycle", 32'(rd_s), 32'd9);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd7);
    chk("sel_high_cycle", 32'(rd_s), 32'd10);

    // clear beats halt and en; read sees pre-clear value
    step(1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 3'd2);
    chk("clear_read", 32'(rd_s), 32'd8);
    chk("clear_running", 32'(run_s), 32'd0);
    chk("clear_frozen", 32'(fr_s), 32'd0);
    chk("clear_ovf", 32'(of_s), 32'd0);

    // async reset mid-RUN
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd0);
    chk("pre_reset_rd", 32'(rd_s), 32'd3);
    #3 rst = 1'b1;
    #1;
    chk("async_rd_data", 32'(rd_s), 32'd0);
    chk("async_rd_valid", 32'(v_s), 32'd0);
    chk("async_running", 32'(run_s), 32'd0);
    chk("async_overflow", 32'(of_w), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    repeat (400)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 19) == 0, NE'($urandom),
           $urandom_range(0, 2) == 0, SW'($urandom));
    repeat (3) step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0);
    chk("queue_drained", 32'(qs.size() + qw.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
